// File: rtl/kernel_kcore_start_pkg.sv
// Shared types and helpers for the start-token arbiter.
package kernel_kcore_start_pkg;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned ID_WIDTH_DEF   = 2;
  localparam int unsigned DATA_WIDTH_DEF = 1;
  localparam int unsigned MAX_OUT_DEF    = 4;
  localparam int unsigned CNT_WIDTH_DEF  = 4;

  // Largest supported requester count; sizes the pick helper.
  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_IDX_W = 4;

  // Credit count (holds up to 15 outstanding tokens).
  typedef logic [CNT_WIDTH_DEF-1:0] credit_t;

  // Token layout written to the FIFO: requester id in the MSBs, payload in the LSBs.
  typedef struct packed {
    logic [ID_WIDTH_DEF-1:0]   id;
    logic [DATA_WIDTH_DEF-1:0] data;
  } token_t;

  // Result of a round-robin pick.
  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of elig at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] elig,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input int unsigned n);
    pick_t r;
    int    j;
    r = '0;
    // Walk backwards so the closest eligible index is written last.
    for (int k = int'(n) - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % int'(n);
      if (elig[j]) begin
        r.found = 1'b1;
        r.idx   = MAX_IDX_W'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/kernel_kcore_start_arbiter_if.sv
// Requester, FIFO-write and credit-return signals of the start arbiter.
interface kernel_kcore_start_arbiter_if
  import kernel_kcore_start_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned ID_WIDTH   = ID_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full_n;
  logic                          fifo_write;
  logic                          fifo_write_ce;
  logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din;
  logic                          done_valid;
  logic [ID_WIDTH-1:0]           done_id;
  logic [NUM_REQ-1:0]            credit_zero;
  logic                          err;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, fifo_full_n, done_valid, done_id,
    output req_ready, fifo_write, fifo_write_ce, fifo_din, credit_zero, err
  );

  // Requester / FIFO / consumer side.
  modport slave (
    output req_valid, req_data, fifo_full_n, done_valid, done_id,
    input  req_ready, fifo_write, fifo_write_ce, fifo_din, credit_zero, err
  );

endinterface

// File: rtl/kernel_kcore_start_arbiter_credit.sv
// Per-requester credit counter bounding outstanding start tokens.
module kernel_kcore_start_arbiter_credit #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic ovf_err_c
);

  localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_OUTSTANDING);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 zero_q;

  // Next count; a return that would exceed the maximum is dropped and flagged.
  always_comb begin
    count_d   = count_q;
    ovf_err_c = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (count_q == MAX_C) ovf_err_c = 1'b1;
        else                  count_d   = count_q + CNT_WIDTH'(1);
      end
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // Count and registered zero flag, kept in step with each other.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= MAX_C;
      zero_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      zero_q  <= (count_d == '0);
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/kernel_kcore_start_arbiter.sv
// Round-robin, credit-limited arbiter sharing one start-FIFO write port.
module kernel_kcore_start_arbiter
  import kernel_kcore_start_pkg::*;
#(
  parameter int unsigned NUM_REQ         = NUM_REQ_DEF,
  parameter int unsigned ID_WIDTH        = ID_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUT_DEF,
  parameter int unsigned CNT_WIDTH       = $bits(credit_t)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  kernel_kcore_start_arbiter_if.master  bus
);

  localparam int unsigned TOK_W = ID_WIDTH + DATA_WIDTH;

  logic                  out_valid;
  logic [TOK_W-1:0]      out_tok;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic                  err_q;

  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    grant_vec;
  logic [NUM_REQ-1:0]    cz;
  logic [NUM_REQ-1:0]    ovf;
  logic [NUM_REQ-1:0]    inc;
  logic                  load;
  logic                  grant;
  pick_t                 pick;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  done_in_range;

  // Grant selection; req_ready is held low during reset and while the output stalls.
  always_comb begin
    elig      = bus.req_valid & ~cz;
    load      = ~out_valid | bus.fifo_full_n;
    pick      = rr_pick(MAX_REQ'(elig), MAX_IDX_W'(rr_ptr), NUM_REQ);
    grant     = reset_n & load & pick.found;
    gnt_id    = ID_WIDTH'(pick.idx);
    gnt_data  = bus.req_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    grant_vec = '0;
    if (grant) grant_vec[gnt_id] = 1'b1;
    done_in_range = ({1'b0, bus.done_id} < (ID_WIDTH+1)'(NUM_REQ));
  end

  // One credit counter per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_credit
    assign inc[i] = bus.done_valid & done_in_range & (bus.done_id == ID_WIDTH'(i));

    kernel_kcore_start_arbiter_credit #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_credit (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc       (inc[i]),
      .dec       (grant_vec[i]),
      .zero      (cz[i]),
      .ovf_err_c (ovf[i])
    );
  end

  // Output register, round-robin pointer and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_tok   <= '0;
      rr_ptr    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (grant) begin
        out_valid <= 1'b1;
        out_tok   <= {gnt_id, gnt_data};
        rr_ptr    <= (32'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_WIDTH'(1);
      end else if (out_valid && bus.fifo_full_n) begin
        out_valid <= 1'b0;
      end
      err_q <= err_q | (|ovf) | (bus.done_valid & ~done_in_range);
    end
  end

  assign bus.req_ready     = grant_vec;
  assign bus.fifo_write    = out_valid;
  assign bus.fifo_write_ce = 1'b1;
  assign bus.fifo_din      = out_tok;
  assign bus.credit_zero   = cz;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_kernel_kcore_start_arbiter.sv
// Scoreboard bench for the start-token arbiter (default 4-requester configuration).
module tb_kernel_kcore_start_arbiter;
  import kernel_kcore_start_pkg::*;

  localparam int unsigned NR  = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned DW  = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  kernel_kcore_start_arbiter_if #(.NUM_REQ(NR), .ID_WIDTH(IDW), .DATA_WIDTH(DW)) bus ();

  kernel_kcore_start_arbiter #(
    .NUM_REQ(NR), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4), .CNT_WIDTH(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [IDW+DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [IDW+DW-1:0] tok(input int id, input logic d);
    token_t t;
    t.id   = IDW'(id);
    t.data = d;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted FIFO write must match the oldest expected token.
  always @(negedge clk) begin
    if (reset_n && bus.fifo_write && bus.fifo_full_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_write actual=%0h expected=none", bus.fifo_din);
      end else begin
        chk("sb_fifo_din", 32'(bus.fifo_din), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    chk("sb_empty_before_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.fifo_full_n = 1'b1;
    bus.done_valid  = 1'b0;
    bus.done_id     = '0;
    reset_n         = 1'b0;
    @(negedge clk);
    chk("rst_fifo_write", 32'(bus.fifo_write), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_credit_zero", 32'(bus.credit_zero), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_fifo_din", 32'(bus.fifo_din), 32'd0);
    chk("rst_write_ce", 32'(bus.fifo_write_ce), 32'd1);
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // Single requester: grant in t, write {2,1} in t+1.
    do_reset();
    bus.req_valid = 4'b0100;
    bus.req_data  = 4'b0100;
    @(negedge clk);
    chk("t1_ready", 32'(bus.req_ready), 32'b0100);
    exp_q.push_back(3'b101);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t1_write", 32'(bus.fifo_write), 32'd1);
    chk("t1_din", 32'(bus.fifo_din), 32'b101);
    tick();
    @(negedge clk);
    chk("t1_idle", 32'(bus.fifo_write), 32'd0);
    tick();

    // Fairness: all valid, credits returned one cycle after each grant.
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      bus.done_valid = (k > 0);
      bus.done_id    = (k > 0) ? IDW'((k - 1) % 4) : '0;
      @(negedge clk);
      chk("t2_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
      if (k > 0) chk("t2_write", 32'(bus.fifo_write), 32'd1);
      exp_q.push_back(tok(k % 4, logic'((k % 4) & 1)));
      tick();
    end
    bus.req_valid  = '0;
    bus.done_valid = 1'b1;
    bus.done_id    = 2'd3;
    @(negedge clk);
    chk("t2_write_last", 32'(bus.fifo_write), 32'd1);
    tick();
    bus.done_valid = 1'b0;
    @(negedge clk);
    chk("t2_credit_zero", 32'(bus.credit_zero), 32'd0);
    chk("t2_err", 32'(bus.err), 32'd0);
    tick();

    // Backpressure: token held for 5 stalled cycles, next grant on release.
    do_reset();
    bus.req_valid = 4'b0011;
    bus.req_data  = 4'b0010;
    @(negedge clk);
    chk("t3_ready0", 32'(bus.req_ready), 32'b0001);
    exp_q.push_back(3'b000);
    tick();
    bus.fifo_full_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_stall_ready", 32'(bus.req_ready), 32'd0);
      chk("t3_stall_din", 32'(bus.fifo_din), 32'b000);
      chk("t3_stall_write", 32'(bus.fifo_write), 32'd1);
      tick();
    end
    bus.fifo_full_n = 1'b1;
    @(negedge clk);
    chk("t3_release_ready", 32'(bus.req_ready), 32'b0010);
    exp_q.push_back(3'b011);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t3_release_din", 32'(bus.fifo_din), 32'b011);
    tick();

    // Credit exhaustion on requester 1, then one credit back.
    do_reset();
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_ready", 32'(bus.req_ready), 32'b0010);
      exp_q.push_back(3'b010);
      tick();
    end
    bus.done_valid = 1'b1;
    bus.done_id    = 2'd1;
    @(negedge clk);
    chk("t4_exhaust_ready", 32'(bus.req_ready), 32'd0);
    chk("t4_credit_zero", 32'(bus.credit_zero), 32'b0010);
    tick();
    bus.done_valid = 1'b0;
    @(negedge clk);
    chk("t4_regrant", 32'(bus.req_ready), 32'b0010);
    exp_q.push_back(3'b010);
    tick();
    @(negedge clk);
    chk("t4_exhaust2_ready", 32'(bus.req_ready), 32'd0);
    chk("t4_credit_zero2", 32'(bus.credit_zero), 32'b0010);
    chk("t4_err", 32'(bus.err), 32'd0);
    tick();
    bus.req_valid = '0;
    tick();

    // Grant and done together on id 2 at credit 2, then overflow by extra done.
    do_reset();
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      bus.done_valid = (k == 2);
      bus.done_id    = 2'd2;
      @(negedge clk);
      chk("t5_ready", 32'(bus.req_ready), 32'b0100);
      exp_q.push_back(3'b100);
      tick();
    end
    bus.req_valid = '0;
    bus.done_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_err_pre", 32'(bus.err), 32'd0);
      tick();
    end
    bus.done_valid = 1'b0;
    @(negedge clk);
    chk("t5_err_set", 32'(bus.err), 32'd1);
    tick();
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_full_ready", 32'(bus.req_ready), 32'b0100);
      exp_q.push_back(3'b100);
      tick();
    end
    @(negedge clk);
    chk("t5_exhaust_ready", 32'(bus.req_ready), 32'd0);
    chk("t5_credit_zero", 32'(bus.credit_zero), 32'b0100);
    chk("t5_err_sticky", 32'(bus.err), 32'd1);
    tick();
    bus.req_valid = '0;
    tick();

    // Reset mid-stream: held token dropped at once, credits restored.
    do_reset();
    bus.req_valid = 4'b1111;
    @(negedge clk);
    chk("t7_ready0", 32'(bus.req_ready), 32'b0001);
    exp_q.push_back(3'b000);
    tick();
    @(negedge clk);
    chk("t7_ready1", 32'(bus.req_ready), 32'b0010);
    exp_q.push_back(3'b010);
    tick();
    reset_n = 1'b0;
    #1;
    chk("t7_async_write", 32'(bus.fifo_write), 32'd0);
    chk("t7_async_ready", 32'(bus.req_ready), 32'd0);
    chk("t7_async_err", 32'(bus.err), 32'd0);
    void'(exp_q.pop_back());
    tick();
    reset_n = 1'b1;
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t7_ready", 32'(bus.req_ready), 32'b0001);
      exp_q.push_back(3'b000);
      tick();
    end
    @(negedge clk);
    chk("t7_exhaust_ready", 32'(bus.req_ready), 32'd0);
    chk("t7_credit_zero", 32'(bus.credit_zero), 32'b0001);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_kcore_start_arbiter.md
Name: kernel_kcore_start_arbiter

Overview:
- Shares one HLS-style start-token FIFO write port between NUM_REQ upstream dataflow processes. It writes into the FIFO that feeds the write-back stage.
- Arbitration is round-robin. Each requester holds a credit count that bounds its outstanding start tokens. The consumer returns credits with a tagged done pulse.
- One registered output stage sits on the FIFO write side, so request-to-FIFO timing is decoupled.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ID_WIDTH, 2, requester index width; must equal clog2(NUM_REQ), minimum 1
- DATA_WIDTH, 1, per-token payload width
- MAX_OUTSTANDING, 4, credits per requester (1..15)
- CNT_WIDTH, 4, credit counter width; must hold MAX_OUTSTANDING

Ports:
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i has a start token
- req_data  in  NUM_REQ*DATA_WIDTH  payload; slice i belongs to requester i
- req_ready  out  NUM_REQ  one-hot grant; a token transfers when req_valid[i] and req_ready[i] are both high
- fifo_full_n  in  1  start FIFO can accept a write
- fifo_write  out  1  FIFO write strobe
- fifo_write_ce  out  1  FIFO write clock-enable; constant 1
- fifo_din  out  ID_WIDTH+DATA_WIDTH  {requester id, payload}
- done_valid  in  1  consumer finished one token
- done_id  in  ID_WIDTH  requester whose token finished
- credit_zero  out  NUM_REQ  requester i has 0 credits
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - out_valid=0; fifo_write=0; req_ready=0
  - rr_ptr=0; every credit=MAX_OUTSTANDING; credit_zero=0; err=0
  - fifo_din=0
- Eligibility: elig[i] = req_valid[i] & (credit[i]!=0).
- Load condition: load = !out_valid | (out_valid & fifo_full_n).
- Grant (combinational):
  - When load and any elig, grant the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready is one-hot on the granted index; otherwise all zero.
  - req_ready never depends on req_valid of the granted index beyond elig; no other comb loops.
- On grant at edge t:
  - Output register takes {i, req_data[i]}; out_valid=1.
  - rr_ptr = (i+1) mod NUM_REQ. rr_ptr is unchanged when there is no grant.
  - credit[i] decrements.
- Output stage:
  - fifo_write = out_valid.
  - The FIFO consumes when fifo_write & fifo_full_n.
  - If the FIFO consumes and there is no new grant, out_valid clears.
  - While fifo_full_n=0, out_valid, fifo_din and rr_ptr hold, and req_ready=0.
- Latency: a grant in cycle t gives fifo_write=1 in cycle t+1. Throughput is 1 token/cycle while fifo_full_n=1.
- Credits:
  - done_valid increments credit[done_id].
  - A grant and a done for the same id in the same cycle leave the credit unchanged.
  - A done that would exceed MAX_OUTSTANDING is dropped and sets err.
  - done_id >= NUM_REQ is dropped and sets err.
- credit_zero[i] is registered and equals (credit[i]==0).
- err clears only on reset.
- Reset mid-operation drops any token held in the output register. Credits restore to full; upstream is responsible for re-synchronising.

Decomposition:
- Package kernel_kcore_start_pkg holds:
  - the token field layout: id field in the MSBs, payload in the LSBs
  - the credit-count type
  - the function rr_pick(elig, ptr) returning index and found flag
- One sub-module, kernel_kcore_start_arbiter_credit: a per-requester credit counter with inc, dec, zero and overflow-error outputs, instantiated NUM_REQ times.
- The round-robin pick and the output register stay in the top module.

Test Plan:
- Single requester: reset, then req_valid=4'b0100 with data=1, fifo_full_n=1 -> req_ready=4'b0100 in cycle t; fifo_write=1 and fifo_din=3'b101 in t+1.
- Fairness: all four requesters valid continuously, MAX_OUTSTANDING=4, done pulses returned immediately -> grant order 0,1,2,3,0,... with no gaps; 8 writes in 8 cycles.
- Backpressure: fifo_full_n=0 for 5 cycles with a token held -> fifo_din stable, req_ready=0 throughout. On fifo_full_n=1, the token writes and the next grant occurs the same cycle.
- Credit exhaustion: requester 1 only, no done -> exactly 4 grants, then credit_zero[1]=1 and req_ready[1]=0. One done_id=1 -> exactly one more grant.
- Simultaneous grant and done on id 2 with credit=2 -> credit stays 2; err=0.
- Error cases:
  - Extra done on a full-credit id -> err=1, credit stays 4.
  - Assert reset_n=0 mid-stream -> fifo_write=0 immediately (async) and all credits back to 4.
